shifter_palette: RTL and testbench

Colour-lookup stage directly downstream of the shifter video path. Samples the 4-bit colour index on each pixel-clock edge and maps it through the 16-entry palette to 4-bit R/G/B, or to a 1-bit mono output in high resolution. Holds the CPU-writable palette register file at word offsets 0–15 of the palette window. Output feeds the video DAC / scan doubler.

---
 rtl/shifter_palette.sv | 136 +++++++++++++
 tb/tb_shifter_palette.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_palette.sv
`default_nettype none
// ============================================================================
// Module   : shifter_palette
// Brief    : Colour-lookup stage behind the shifter. Samples the colour index
//            on pixClk rising edges, maps it through a 16-entry CPU-writable
//            palette to 4-bit R/G/B (or a 1-bit mono pixel) two clksys edges
//            later. Palette entries are 12-bit (STE) or 9-bit (ST).
// Revision : 1.0 - initial release
// ============================================================================
module shifter_palette #(
  parameter bit STE = 1'b1
) (
  input  logic        clksys,
  input  logic        nReset,
  input  logic        pixClk,
  input  logic        DE,
  input  logic        blank,
  input  logic [1:0]  rez,
  input  logic [3:0]  color_index,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [3:0]  cpu_addr,
  input  logic [1:0]  cpu_bsel,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        mono_out
);

  // ST parts keep only the three low bits of each nibble.
  localparam logic [15:0] c_entry_mask = STE ? 16'h0FFF : 16'h0777;
  localparam logic [1:0]  c_rez_mono   = 2'b10;

  logic [15:0] pal_q [16];
  logic        pixClk_D;
  logic        cs_D;
  logic        pe;
  logic        ce;
  logic        pe_q;
  logic [3:0]  idx_q;
  logic        blank_q;
  logic        mono_q;
  logic [15:0] wr_d;
  logic [11:0] rgb_d;
  logic        mono_d;

  // Nibble to 4-bit DAC code: replicate an LSB into the bottom bit.
  function automatic logic [3:0] expand(input logic [3:0] c);
    return {c[2:0], (STE ? c[3] : c[2])};
  endfunction

  assign pe = pixClk & ~pixClk_D;
  assign ce = cpu_cs & ~cs_D;

  // Delayed copies for rising-edge detection; pe_q marks the stage-2 cycle.
  always_ff @(posedge clksys or negedge nReset) begin
    if (!nReset) begin
      pixClk_D <= 1'b0;
      cs_D     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      pixClk_D <= pixClk;
      cs_D     <= cpu_cs;
      pe_q     <= pe;
    end
  end

  // Stage 1: capture the pixel attributes on a pixel-clock rising edge.
  always_ff @(posedge clksys or negedge nReset) begin
    if (!nReset) begin
      idx_q   <= 4'h0;
      blank_q <= 1'b0;
      mono_q  <= 1'b0;
    end else if (pe) begin
      idx_q   <= DE ? color_index : 4'h0;
      blank_q <= blank;
      mono_q  <= (rez == c_rez_mono);
    end
  end

  // Lookup result; mono is white when index bit 0 matches palette 0 bit 0.
  always_comb begin
    mono_d = ~blank_q & (idx_q[0] ^ ~pal_q[0][0]);
    rgb_d  = 12'h000;
    if (blank_q) begin
      rgb_d = 12'h000;
    end else if (mono_q) begin
      rgb_d = {12{mono_d}};
    end else begin
      rgb_d = {expand(pal_q[idx_q][11:8]),
               expand(pal_q[idx_q][7:4]),
               expand(pal_q[idx_q][3:0])};
    end
  end

  // Stage 2: register the outputs; they hold between pixel updates.
  always_ff @(posedge clksys or negedge nReset) begin
    if (!nReset) begin
      r        <= 4'h0;
      g        <= 4'h0;
      b        <= 4'h0;
      mono_out <= 1'b0;
    end else if (pe_q) begin
      {r, g, b} <= rgb_d;
      mono_out  <= mono_d;
    end
  end

  // Merged write word: unselected byte lanes keep their current contents.
  always_comb begin
    wr_d = pal_q[cpu_addr];
    if (cpu_bsel[1]) wr_d[15:8] = cpu_din[15:8];
    if (cpu_bsel[0]) wr_d[7:0]  = cpu_din[7:0];
    wr_d = wr_d & c_entry_mask;
  end

  // CPU access on the cs rising edge; a same-edge lookup still sees the old entry.
  always_ff @(posedge clksys or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= 16'h0000;
      cpu_dout <= 16'h0000;
      cpu_ack  <= 1'b0;
    end else begin
      cpu_ack <= ce;
      if (ce) begin
        if (cpu_rw) cpu_dout        <= pal_q[cpu_addr];
        else        pal_q[cpu_addr] <= wr_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shifter_palette.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_palette
// Brief    : Bench for shifter_palette; drives an STE and an ST instance from
//            one bus and compares both against a palette model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shifter_palette;

  logic        clksys = 1'b0;
  logic        nReset, pixClk, DE, blank, cpu_cs, cpu_rw;
  logic [1:0]  rez, cpu_bsel;
  logic [3:0]  color_index, cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] dout1, dout0;
  logic        ack1, ack0, mono1, mono0;
  logic [3:0]  r1, g1, b1, r0, g0, b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m1 [16];
  logic [15:0] m0 [16];
  logic [15:0] prev1, prev0;

  shifter_palette #(.STE(1'b1)) u_ste (
    .clksys(clksys), .nReset(nReset), .pixClk(pixClk), .DE(DE), .blank(blank),
    .rez(rez), .color_index(color_index), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_bsel(cpu_bsel), .cpu_din(cpu_din),
    .cpu_dout(dout1), .cpu_ack(ack1), .r(r1), .g(g1), .b(b1), .mono_out(mono1));

  shifter_palette #(.STE(1'b0)) u_st (
    .clksys(clksys), .nReset(nReset), .pixClk(pixClk), .DE(DE), .blank(blank),
    .rez(rez), .color_index(color_index), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_bsel(cpu_bsel), .cpu_din(cpu_din),
    .cpu_dout(dout0), .cpu_ack(ack0), .r(r0), .g(g0), .b(b0), .mono_out(mono0));

  always #5 clksys = ~clksys;

  task automatic tick;
    @(posedge clksys);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model: channel expansion as DAC arithmetic.
  function automatic logic [3:0] mexp(input logic [3:0] c, input bit ste);
    int v, lsb;
    v   = int'(c);
    lsb = ste ? (v / 8) : ((v / 4) % 2);
    return 4'(((v % 8) * 2) + lsb);
  endfunction

  // Model: byte-lane write followed by format masking.
  function automatic logic [15:0] mwrite(input logic [15:0] old, input logic [1:0] bs,
                                         input logic [15:0] d, input bit ste);
    logic [15:0] v;
    v = old;
    if (bs[1]) v[15:8] = d[15:8];
    if (bs[0]) v[7:0]  = d[7:0];
    return v & (ste ? 16'h0FFF : 16'h0777);
  endfunction

  // Model: expected {mono, r, g, b} for one pixel.
  function automatic logic [15:0] mpix(input logic [15:0] ent, input logic p0, input logic [3:0] ei,
                                       input logic bl, input logic mono, input bit ste);
    logic m;
    m = !bl && (ei[0] == p0);
    if (bl)        return 16'h0000;
    else if (mono) return {3'b000, m, {12{m}}};
    else           return {3'b000, m, mexp(ent[11:8], ste), mexp(ent[7:4], ste), mexp(ent[3:0], ste)};
  endfunction

  task automatic check_pix(input string tag, input logic [15:0] e1, input logic [15:0] e0);
    check({tag, "_ste"}, {3'b000, mono1, r1, g1, b1}, e1);
    check({tag, "_st"},  {3'b000, mono0, r0, g0, b0}, e0);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [1:0] bs, input logic [15:0] d);
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_bsel = bs; cpu_din = d;
    tick;
    m1[a] = mwrite(m1[a], bs, d, 1'b1);
    m0[a] = mwrite(m0[a], bs, d, 1'b0);
    check("wr_ack", {14'd0, ack1, ack0}, 16'h0003);
    cpu_cs = 1'b0;
    tick;
    check("wr_ack_end", {14'd0, ack1, ack0}, 16'h0000);
  endtask

  task automatic cpu_read(input logic [3:0] a);
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = a; cpu_bsel = 2'($urandom); cpu_din = 16'($urandom);
    tick;
    check("rd_ack", {14'd0, ack1, ack0}, 16'h0003);
    check("rd_ste", dout1, m1[a]);
    check("rd_st",  dout0, m0[a]);
    cpu_cs = 1'b0;
    cpu_addr = 4'($urandom);
    tick;
    check("rd_hold", dout1 ^ dout0, m1[a] ^ m0[a]);
  endtask

  // One pixel; with coll set, a write to entry 0 lands on the stage-2 edge.
  task automatic pixel(input logic [3:0] idx, input logic de, input logic bl,
                       input logic [1:0] rz, input bit coll, input logic [15:0] cdata);
    logic [3:0]  ei;
    logic [15:0] e1, e0;
    color_index = idx; DE = de; blank = bl; rez = rz; pixClk = 1'b1;
    tick;
    pixClk = 1'b0;
    color_index = 4'($urandom); DE = 1'($urandom); blank = 1'($urandom); rez = 2'($urandom);
    check_pix("pix_latency", prev1, prev0);
    ei = de ? idx : 4'h0;
    e1 = mpix(m1[ei], m1[0][0], ei, bl, rz == 2'b10, 1'b1);
    e0 = mpix(m0[ei], m0[0][0], ei, bl, rz == 2'b10, 1'b0);
    if (coll) begin
      cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 4'h0; cpu_bsel = 2'b11; cpu_din = cdata;
    end
    tick;
    check_pix("pix", e1, e0);
    prev1 = e1;
    prev0 = e0;
    if (coll) begin
      m1[0] = mwrite(m1[0], 2'b11, cdata, 1'b1);
      m0[0] = mwrite(m0[0], 2'b11, cdata, 1'b0);
      check("coll_ack", {14'd0, ack1, ack0}, 16'h0003);
      cpu_cs = 1'b0;
    end
    tick;
    check_pix("pix_hold", prev1, prev0);
  endtask

  initial begin
    nReset = 1'b0; pixClk = 1'b0; DE = 1'b0; blank = 1'b0; rez = 2'b00; color_index = 4'h0;
    cpu_cs = 1'b0; cpu_rw = 1'b0; cpu_addr = 4'h0; cpu_bsel = 2'b00; cpu_din = 16'h0000;
    for (int i = 0; i < 16; i++) begin m1[i] = 16'h0; m0[i] = 16'h0; end
    prev1 = 16'h0; prev0 = 16'h0;

    // Reset state
    tick; tick;
    check_pix("rst_pix", 16'h0000, 16'h0000);
    check("rst_dout", dout1 | dout0, 16'h0000);
    check("rst_ack", {14'd0, ack1, ack0}, 16'h0000);
    nReset = 1'b1;
    tick;
    for (int a = 0; a < 16; a++) cpu_read(4'(a));

    // STE entry format and expansion
    cpu_write(4'd5, 2'b11, 16'hF9A3);
    cpu_read(4'd5);
    check("rd_f9a3", dout1, 16'h09A3);
    pixel(4'd5, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0);

    // ST masking
    cpu_write(4'd6, 2'b11, 16'h0FFF);
    cpu_read(4'd6);
    check("rd_st_0fff", dout0, 16'h0777);
    pixel(4'd6, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0);

    // Byte enables
    cpu_write(4'd2, 2'b11, 16'h0123);
    cpu_write(4'd2, 2'b01, 16'h0F45);
    cpu_read(4'd2);
    check("rd_bsel", dout1, 16'h0145);

    // Border and blank
    cpu_write(4'd0, 2'b11, 16'h0700);
    pixel(4'd9, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0);
    check("border_ste", {4'h0, r1, g1, b1}, 16'h0E00);
    pixel(4'd9, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0);

    // Mono and collision
    cpu_write(4'd0, 2'b11, 16'h0000);
    pixel(4'd1, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0);
    pixel(4'd1, 1'b1, 1'b0, 2'b10, 1'b1, 16'h0001);
    pixel(4'd1, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0);
    pixel(4'd0, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0);

    // A held cs gives a single access
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 4'd5;
    tick;
    check("held_ack1", {14'd0, ack1, ack0}, 16'h0003);
    tick;
    check("held_ack2", {14'd0, ack1, ack0}, 16'h0000);
    tick;
    check("held_ack3", {14'd0, ack1, ack0}, 16'h0000);
    cpu_cs = 1'b0;
    tick;

    // Randomized mix against the model
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0:       cpu_write(4'($urandom), 2'($urandom), 16'($urandom));
        1:       cpu_read(4'($urandom));
        default: pixel(4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                       2'($urandom), ($urandom_range(0, 4) == 0), 16'($urandom));
      endcase
    end

    // Reset in the middle of a write discards it
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 4'd3; cpu_bsel = 2'b11; cpu_din = 16'hFFFF;
    nReset = 1'b0;
    #1;
    check_pix("rst_async_pix", 16'h0000, 16'h0000);
    cpu_cs = 1'b0;
    tick;
    nReset = 1'b1;
    for (int i = 0; i < 16; i++) begin m1[i] = 16'h0; m0[i] = 16'h0; end
    prev1 = 16'h0; prev0 = 16'h0;
    check("rst_mid_ack", {14'd0, ack1, ack0}, 16'h0000);
    tick;
    check("rst_mid_ack2", {14'd0, ack1, ack0}, 16'h0000);
    cpu_read(4'd3);
    pixel(4'd3, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
